// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with full-scan debounce.
// Emits a key code and one-cycle strobe for each newly accepted single key.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic       clock_50Mhz,
  input  logic       reset_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    CL_NONE,
    CL_KEY,
    CL_MULTI
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [3:0] idx;
  } cls_t;

  localparam cls_t CLS_NONE = '{kind: CL_NONE, idx: 4'd0};

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [CW-1:0] slot;
  logic [1:0]    row;
  logic          slot_last;
  logic [15:0]   snap;
  logic          scan_end;
  logic          upd;
  logic [4:0]    ones;
  logic [3:0]    last_idx;
  cls_t          cls;
  cls_t          cand;
  logic [SW-1:0] stable;
  logic          accept;
  cls_t          deb_q;
  cls_t          deb_d;
  logic [3:0]    code_d;
  logic          valid_d;
  logic          held_d;

  assign slot_last = (slot == SLOT_LAST);

  // two-flop synchroniser on the raw column lines
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 4'b1111;
      sync2 <= 4'b1111;
    end else begin
      sync1 <= col_in;
      sync2 <= sync1;
    end
  end

  // row slot timer, registered one-hot row drive and snapshot capture
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      slot     <= '0;
      row      <= 2'd0;
      row_out  <= 4'b0111;
      snap     <= '0;
      scan_end <= 1'b0;
    end else begin
      scan_end <= slot_last && (row == 2'd3);
      if (slot_last) begin
        slot                   <= '0;
        row                    <= row + 2'd1;
        row_out                <= {row_out[0], row_out[3:1]};
        snap[{row, 2'b00} +: 4] <= ~sync2;
      end else begin
        slot <= slot + CW'(1);
      end
    end
  end

  // classify the completed snapshot as none, one key or several keys
  always_comb begin
    ones     = 5'd0;
    last_idx = 4'd0;
    cls      = CLS_NONE;
    for (int i = 0; i < 16; i++) begin
      if (snap[i]) begin
        ones     = ones + 5'd1;
        last_idx = 4'(i);
      end
    end
    if (ones == 5'd1) begin
      cls.kind = CL_KEY;
      cls.idx  = last_idx;
    end else if (ones > 5'd1) begin
      cls.kind = CL_MULTI;
    end
  end

  // count consecutive identical scan classifications
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      cand   <= CLS_NONE;
      stable <= '0;
      upd    <= 1'b0;
    end else begin
      upd <= scan_end;
      if (scan_end) begin
        if (cls == cand) begin
          if (stable != STABLE_MAX)
            stable <= stable + SW'(1);
        end else begin
          cand   <= cls;
          stable <= SW'(1);
        end
      end
    end
  end

  assign accept = upd && (stable == STABLE_MAX) && (cand != deb_q);

  // next debounced state and key outputs
  always_comb begin
    deb_d   = deb_q;
    code_d  = key_code;
    valid_d = 1'b0;
    if (accept) begin
      deb_d = cand;
      unique case (1'b1)
        (cand.kind == CL_KEY): begin
          code_d  = cand.idx;
          valid_d = 1'b1;
        end
        default: ;
      endcase
    end
    held_d = (deb_d.kind == CL_KEY);
  end

  // debounced state and output registers
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      deb_q     <= CLS_NONE;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      deb_q     <= deb_d;
      key_code  <= code_d;
      key_valid <= valid_d;
      key_held  <= held_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner.
// Small scan timing with a behavioural keypad matrix model.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = 16'h0000;
  logic [3:0]  rows [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  int vectors = 0;
  int fails   = 0;
  int pulses  = 0;
  int cyc_n   = 0;
  int t0      = 0;
  int p0      = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clock_50Mhz(clk),
    .reset_n(reset_n),
    .col_in(col_in),
    .row_out(row_out),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  // keypad matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    col_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row_out[3-r])
          col_in[c] = 1'b0;
  end

  // cycle counter and strobe counter
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (key_valid === 1'b1)
      pulses <= pulses + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic at(input int e);
    repeat (e - (cyc_n - t0)) @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    reset_n = 1'b1;
    t0 = cyc_n;
  endtask

  initial begin
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_row", 16'(row_out), 16'h7);
    chk("rst_code", 16'(key_code), 16'h0);
    chk("rst_valid", 16'(key_valid), 16'h0);
    chk("rst_held", 16'(key_held), 16'h0);
    release_rst();

    // idle scanning
    p0 = pulses;
    for (int e = 0; e < 32; e++) begin
      if (e > 0) at(e);
      chk($sformatf("s1_row_e%0d", e), 16'(row_out), 16'(rows[(e/4)%4]));
    end
    at(64);
    chk("s1_pulses", 16'(pulses - p0), 16'h0);
    chk("s1_held", 16'(key_held), 16'h0);

    // key 9 pressed and held
    pressed = 16'h0200;
    p0 = pulses;
    at(113);
    chk("s2_valid_pre", 16'(key_valid), 16'h0);
    chk("s2_held_pre", 16'(key_held), 16'h0);
    at(114);
    chk("s2_valid", 16'(key_valid), 16'h1);
    chk("s2_code", 16'(key_code), 16'h9);
    chk("s2_held", 16'(key_held), 16'h1);
    at(115);
    chk("s2_valid_post", 16'(key_valid), 16'h0);
    at(200);
    chk("s2_pulses", 16'(pulses - p0), 16'h1);
    chk("s2_held_long", 16'(key_held), 16'h1);

    // release key 9
    at(208);
    pressed = 16'h0000;
    p0 = pulses;
    at(257);
    chk("s3_held_pre", 16'(key_held), 16'h1);
    at(258);
    chk("s3_held", 16'(key_held), 16'h0);
    chk("s3_code", 16'(key_code), 16'h9);
    chk("s3_valid", 16'(key_valid), 16'h0);
    at(264);
    chk("s3_pulses", 16'(pulses - p0), 16'h0);

    // key 5 bouncing every scan
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      at(272 + 16*i);
      pressed = (i % 2 == 0) ? 16'h0020 : 16'h0000;
      chk($sformatf("s4_held_%0d", i), 16'(key_held), 16'h0);
    end
    at(432);
    pressed = 16'h0000;
    at(440);
    chk("s4_pulses", 16'(pulses - p0), 16'h0);
    chk("s4_held", 16'(key_held), 16'h0);
    chk("s4_code", 16'(key_code), 16'h9);

    // key 0, then 0+15 (multi), then 15 alone
    at(448);
    pressed = 16'h0001;
    p0 = pulses;
    at(497);
    chk("s5_k0_valid_pre", 16'(key_valid), 16'h0);
    at(498);
    chk("s5_k0_valid", 16'(key_valid), 16'h1);
    chk("s5_k0_code", 16'(key_code), 16'h0);
    chk("s5_k0_held", 16'(key_held), 16'h1);
    at(512);
    pressed = 16'h8001;
    at(561);
    chk("s5_multi_pre", 16'(key_held), 16'h1);
    at(562);
    chk("s5_multi_held", 16'(key_held), 16'h0);
    chk("s5_multi_code", 16'(key_code), 16'h0);
    chk("s5_multi_valid", 16'(key_valid), 16'h0);
    at(576);
    pressed = 16'h8000;
    chk("s5_multi_pulses", 16'(pulses - p0), 16'h1);
    at(625);
    chk("s5_k15_valid_pre", 16'(key_valid), 16'h0);
    at(626);
    chk("s5_k15_valid", 16'(key_valid), 16'h1);
    chk("s5_k15_code", 16'(key_code), 16'hF);
    chk("s5_k15_held", 16'(key_held), 16'h1);
    at(627);
    chk("s5_k15_valid_post", 16'(key_valid), 16'h0);

    // key 3 held across a mid-scan reset
    at(640);
    pressed = 16'h0008;
    at(664);
    chk("s6_pre_code", 16'(key_code), 16'hF);
    chk("s6_pre_row", 16'(row_out), 16'hD);
    #1 reset_n = 1'b0;
    #1;
    chk("s6_rst_row", 16'(row_out), 16'h7);
    chk("s6_rst_code", 16'(key_code), 16'h0);
    chk("s6_rst_valid", 16'(key_valid), 16'h0);
    chk("s6_rst_held", 16'(key_held), 16'h0);
    repeat (2) @(posedge clk);
    release_rst();
    p0 = pulses;
    chk("s6_row0", 16'(row_out), 16'h7);
    at(49);
    chk("s6_valid_pre", 16'(key_valid), 16'h0);
    chk("s6_held_pre", 16'(key_held), 16'h0);
    at(50);
    chk("s6_valid", 16'(key_valid), 16'h1);
    chk("s6_code", 16'(key_code), 16'h3);
    chk("s6_held", 16'(key_held), 16'h1);
    at(51);
    chk("s6_valid_post", 16'(key_valid), 16'h0);
    at(100);
    chk("s6_pulses", 16'(pulses - p0), 16'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad by driving one row low at a time and reading four pulled-up column inputs. Raw column samples are synchronised and assembled into a full-matrix snapshot once per scan. A debouncer requires a stable snapshot over several scans. Each newly debounced single-key press produces a 4-bit key code and a one-cycle strobe. This is the input-side companion to the multiplexed 7-segment display driver on the same board and uses the same active-low, one-hot row scan pattern.

Parameters:
SCAN_DIV, 50000, clock cycles each row is held active (1 ms at 50 MHz); minimum 4.
DEBOUNCE_SCANS, 20, number of consecutive identical full-scan results required to accept a new state; minimum 2.

Ports:
clock_50Mhz  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
col_in  input  4  keypad columns, active-low (pulled up externally); bit i = column i
row_out  output  4  keypad rows, active-low one-hot; row r drives bit (3-r) low
key_code  output  4  last accepted key, equal to row*4 + col
key_valid  output  1  one-cycle pulse when key_code is updated with a newly accepted key
key_held  output  1  high while the debounced state is a single pressed key

Behaviour:
- Reset (async, reset_n=0):
  - row index 0, so row_out=4'b0111.
  - Row-slot counter 0.
  - Snapshot, candidate and debounced state cleared; debounced state = NONE.
  - Stable count 0.
  - key_code=0, key_valid=0, key_held=0.
  - Synchroniser flops set to 4'b1111.
- col_in passes through a 2-FF synchroniser before any use.
- Row scan:
  - Row-slot counter counts 0..SCAN_DIV-1.
  - On the last count, sample the synchronised columns into snapshot bits [row*4+3 : row*4], inverted so 1 = pressed.
  - Then advance the row 0→1→2→3→0.
  - row_out = ~(4'b1000 >> row); it changes only at slot boundaries, never glitches, and exactly one bit is low at all times.
- Scan end is the sample cycle of row 3. Classify the 16-bit snapshot:
  - zero bits set → NONE
  - exactly one bit set → KEY(n), n = bit index
  - two or more bits set → MULTI
- Debounce, updated one cycle after scan end:
  - If classification equals the previous classification, stable count increments and saturates at DEBOUNCE_SCANS.
  - Otherwise the previous classification is replaced and stable count is set to 1.
- Acceptance: when stable count first reaches DEBOUNCE_SCANS and the classification differs from the debounced state, the debounced state takes the classification. Then:
  - KEY(n): key_code<=n, key_valid=1 for exactly one cycle (two cycles after the row-3 sample edge), key_held=1.
  - NONE: key_held=0; key_code retained; no pulse.
  - MULTI: key_held=0; key_code retained; no pulse. Ghost/rollover presses are never reported.
- Direct transition KEY(a)→KEY(b), with no NONE in between, once stable: key_valid pulses again with key_code=b.
- A held key never re-pulses (no auto-repeat).
- Any bounce shorter than DEBOUNCE_SCANS scans produces no output change.
- The first scan after reset uses the same rules; a key pressed through reset is reported only after DEBOUNCE_SCANS full scans.
- Reset asserted mid-scan or mid-debounce discards all partial state immediately.
- Worst-case press-to-strobe latency: (DEBOUNCE_SCANS+1) × 4 × SCAN_DIV + 4 cycles.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3, giving a 16-cycle scan.
1. Release reset with no keys pressed → row_out sequence 0111,1011,1101,1110 with each value held 4 cycles and repeating; key_valid never asserts; key_held=0.
2. Model key row 2 / col 1 pressed and held (col_in[1] low while row_out=1101) → after 3 stable scans key_valid pulses once for one cycle with key_code=9; key_held=1; no further pulses while held.
3. Release the key of scenario 2 → key_held drops 3 scans after release; no pulse; key_code stays 9.
4. Toggle key 5 (row 1 / col 1) on and off every scan for 10 scans → no key_valid; key_held=0.
5. Hold key 0 until accepted, then also press key 15 → MULTI after 3 scans: key_held=0, key_code=0, no pulse. Release key 0 leaving only key 15 → pulse with key_code=15.
6. Hold key 3 and assert reset_n=0 mid-scan for 2 cycles → outputs return to reset values at once; key_valid with key_code=3 asserts 3 full scans after reset deassertion.
